// File: rtl/main_mem_responder_if.sv
// rtl/main_mem_responder_if.sv - L2 word port bundle between the L2 cache and the memory responder
interface main_mem_responder_if #(
  parameter int CW = 3
);
  logic [31:0]   mem_addr;
  logic          mem_renable;
  logic          mem_wenable;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_rvalid;
  logic          mem_busy;
  logic [CW-1:0] wbuf_count;
  logic          err_overflow;
  logic          err_conflict;

  modport master (
    output mem_addr, mem_renable, mem_wenable, mem_wdata,
    input  mem_rdata, mem_rvalid, mem_busy, wbuf_count, err_overflow, err_conflict
  );

  modport slave (
    input  mem_addr, mem_renable, mem_wenable, mem_wdata,
    output mem_rdata, mem_rvalid, mem_busy, wbuf_count, err_overflow, err_conflict
  );
endinterface

// File: rtl/main_mem_responder.sv
// rtl/main_mem_responder.sv - word array with fixed-latency reads and a forwarding posted write queue
module main_mem_responder #(
  parameter int AW         = 10,
  parameter int READ_LAT   = 1,
  parameter int WBUF_DEPTH = 4,
  parameter int WR_CYCLES  = 2
) (
  input logic               clk,
  input logic               rst,
  main_mem_responder_if.slave bus
);
  localparam int PW    = $clog2(WBUF_DEPTH);
  localparam int CW    = PW + 1;
  localparam int TW    = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam int WORDS = 1 << AW;

  typedef enum logic {ST_IDLE, ST_WRITING} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   cyc_q, cyc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, tail_q;
  logic [31:0]     mem_q   [WORDS];
  logic [AW-1:0]   qidx_q  [WBUF_DEPTH];
  logic [31:0]     qdata_q [WBUF_DEPTH];
  logic [31:0]     rdata_q [READ_LAT];
  logic [READ_LAT-1:0] rvld_q;
  logic            err_ovf_q, err_cnf_q;

  logic [AW-1:0]   idx;
  logic            rd, wr_req, full, push, pop;
  logic [31:0]     snap;
  logic [PW-1:0]   fwd_slot;
  logic            unused_addr_bits;

  assign idx              = bus.mem_addr[AW+1:2];
  assign unused_addr_bits = ^{bus.mem_addr[31:AW+2], bus.mem_addr[1:0]};
  assign rd               = bus.mem_renable;
  assign wr_req           = bus.mem_wenable & ~bus.mem_renable;
  assign full             = (count_q == CW'(WBUF_DEPTH));
  assign push             = wr_req & ~full;

  // Walk oldest to newest so the newest matching queued write wins over the array.
  always_comb begin
    snap     = mem_q[idx];
    fwd_slot = head_q;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      fwd_slot = head_q + PW'(k);
      if ((CW'(k) < count_q) && (qidx_q[fwd_slot] == idx)) snap = qdata_q[fwd_slot];
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) state_d = ST_WRITING;
      end
      ST_WRITING: begin
        // A read owns the array port this cycle, so the drain makes no progress.
        if (!rd) begin
          if (cyc_q == TW'(WR_CYCLES - 1)) begin
            pop   = 1'b1;
            cyc_d = '0;
            if ((count_q == CW'(1)) && !push) state_d = ST_IDLE;
          end else begin
            cyc_d = cyc_q + TW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      rvld_q    <= '0;
      err_ovf_q <= 1'b0;
      err_cnf_q <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) rdata_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      count_q <= count_d;
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      rvld_q[0] <= rd;
      if (rd) rdata_q[0] <= snap;
      // Stages load only on a valid so the last stage holds the previous response.
      for (int i = 1; i < READ_LAT; i++) begin
        rvld_q[i] <= rvld_q[i-1];
        if (rvld_q[i-1]) rdata_q[i] <= rdata_q[i-1];
      end
      if (wr_req && full)                  err_ovf_q <= 1'b1;
      if (rd && bus.mem_wenable)           err_cnf_q <= 1'b1;
    end
  end

  // Storage has no reset: the array must survive rst, and stale queue slots are masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      qidx_q[tail_q]  <= idx;
      qdata_q[tail_q] <= bus.mem_wdata;
    end
    if (pop) mem_q[qidx_q[head_q]] <= qdata_q[head_q];
  end

  assign bus.mem_rdata    = rdata_q[READ_LAT-1];
  assign bus.mem_rvalid   = rvld_q[READ_LAT-1];
  assign bus.mem_busy     = full;
  assign bus.wbuf_count   = count_q;
  assign bus.err_overflow = err_ovf_q;
  assign bus.err_conflict = err_cnf_q;
endmodule

// File: tb/tb_main_mem_responder.sv
// tb/tb_main_mem_responder.sv - directed vector bench for main_mem_responder
module tb_main_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  main_mem_responder_if #(.CW(3)) bus ();

  main_mem_responder #(
    .AW(10), .READ_LAT(1), .WBUF_DEPTH(4), .WR_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] wdata);
    bus.mem_renable = ren;
    bus.mem_wenable = wen;
    bus.mem_addr    = addr;
    bus.mem_wdata   = wdata;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (bus.wbuf_count != 3'd0 && n < 100) begin
      tick();
      n++;
    end
    chk(name, {31'd0, bus.wbuf_count == 3'd0}, 32'd1);
  endtask

  task automatic write_drain(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b0, 1'b1, addr, data);
    tick();
    chk("preload_count", {29'd0, bus.wbuf_count}, 32'd1);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    wait_empty("preload_drain");
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdata"}, bus.mem_rdata, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, bus.mem_rvalid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.mem_busy}, 32'd0);
    chk({tag, "_count"}, {29'd0, bus.wbuf_count}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, bus.err_overflow}, 32'd0);
    chk({tag, "_cnf"}, {31'd0, bus.err_conflict}, 32'd0);
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b1, 1'b0, addr, 32'd0);
    tick();
    chk({name, "_rvalid"}, {31'd0, bus.mem_rvalid}, 32'd1);
    chk({name, "_rdata"}, bus.mem_rdata, exp);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic vec_t mk(input logic ren, input logic wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic ev,
                              input logic [31:0] ed, input logic [2:0] ec);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata;
    v.exp_rvalid = ev; v.exp_rdata = ed; v.exp_count = ec;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Read hits, line fill, forwarding and duplicate-index ordering; rdata holds between responses.
    vecs.push_back(mk(1, 0, 32'h14, 0, 1, 32'hA5A5A5A5, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 32'h20 + 32'(4 * i), 0, 1, 32'hC0DE0000 + 32'(i), 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'hC0DE0007, 0));
    vecs.push_back(mk(0, 1, 32'h40, 32'h11111111, 0, 32'hC0DE0007, 1));
    vecs.push_back(mk(1, 0, 32'h40, 0, 1, 32'h11111111, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 32'h11111111, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h11111111, 0));
    vecs.push_back(mk(1, 0, 32'h40, 0, 1, 32'h11111111, 0));
    vecs.push_back(mk(0, 1, 32'h08, 32'd1, 0, 32'h11111111, 1));
    vecs.push_back(mk(0, 1, 32'h08, 32'd2, 0, 32'h11111111, 2));
    vecs.push_back(mk(1, 0, 32'h08, 0, 1, 32'd2, 2));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 32'd2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'd2, 1));
    vecs.push_back(mk(1, 0, 32'h08, 0, 1, 32'd2, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 32'd2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'd2, 0));
    vecs.push_back(mk(1, 0, 32'h08, 0, 1, 32'd2, 0));
    vecs.push_back(mk(1, 0, 32'h1014, 0, 1, 32'hA5A5A5A5, 0));
    vecs.push_back(mk(1, 0, 32'h16, 0, 1, 32'hA5A5A5A5, 0));

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("post_reset");

    write_drain(32'h14, 32'hA5A5A5A5);
    for (int i = 0; i < 8; i++) write_drain(32'h20 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
    write_drain(32'h10, 32'h10101010);
    write_drain(32'h110, 32'hDEADBEEF);

    foreach (vecs[i]) begin
      drive(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      tick();
      chk($sformatf("vec%0d_rvalid", i), {31'd0, bus.mem_rvalid}, {31'd0, vecs[i].exp_rvalid});
      chk($sformatf("vec%0d_rdata", i), bus.mem_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_count", i), {29'd0, bus.wbuf_count}, {29'd0, vecs[i].exp_count});
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);

    // Overflow: four accepted writes fill the queue while the first is still draining.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 32'h100 + 32'(4 * k), 32'h50 + 32'(k));
      tick();
      chk($sformatf("fill%0d_count", k), {29'd0, bus.wbuf_count}, 32'(k + 1));
    end
    chk("full_busy", {31'd0, bus.mem_busy}, 32'd1);
    chk("full_ovf", {31'd0, bus.err_overflow}, 32'd0);
    drive(1'b0, 1'b1, 32'h110, 32'h99999999);
    tick();
    chk("drop_count", {29'd0, bus.wbuf_count}, 32'd4);
    chk("drop_ovf", {31'd0, bus.err_overflow}, 32'd1);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    wait_empty("ovf_drain");
    chk("ovf_sticky", {31'd0, bus.err_overflow}, 32'd1);
    chk("drained_busy", {31'd0, bus.mem_busy}, 32'd0);
    for (int k = 0; k < 4; k++)
      read_chk($sformatf("ovf_arr%0d", k), 32'h100 + 32'(4 * k), 32'h50 + 32'(k));
    read_chk("dropped_arr", 32'h110, 32'hDEADBEEF);

    // Conflict: read wins, write dropped.
    drive(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF);
    tick();
    chk("cnf_rvalid", {31'd0, bus.mem_rvalid}, 32'd1);
    chk("cnf_rdata", bus.mem_rdata, 32'h10101010);
    chk("cnf_count", {29'd0, bus.wbuf_count}, 32'd0);
    chk("cnf_flag", {31'd0, bus.err_conflict}, 32'd1);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    read_chk("cnf_after", 32'h10, 32'h10101010);

    // Reset while the drain is mid-entry and a read is being issued.
    drive(1'b0, 1'b1, 32'h10, 32'h77777777);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    chk("pre_rst_count", {29'd0, bus.wbuf_count}, 32'd1);
    drive(1'b1, 1'b0, 32'h10, 32'd0);
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    tick();
    chk("rst_read_rvalid", {31'd0, bus.mem_rvalid}, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rel%0d_rvalid", k), {31'd0, bus.mem_rvalid}, 32'd0);
    end
    chk_zero("rst_release");
    read_chk("rst_array_kept", 32'h10, 32'h10101010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
